// File: rtl/serial_link_pkg.sv
// Shared definitions for both ends of the single-wire serial link.
// Holds the frame state encoding, line levels and the parity reduction.
package serial_link_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } link_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    localparam int MAX_DATA_W = 16;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [MAX_DATA_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Baud counter: tick marks the last cycle of each bit period, pre_tick the one before it.
// Held at zero while clear is high so a new bit period starts cleanly after a handshake.
module bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick,
    output logic pre_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick     = (cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign pre_tick = (cnt == CNT_W'(CLKS_PER_BIT - 2));

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start, DATA_W bits LSB-first, optional even parity, stop.
// Start bit drives the line the cycle after handshake; tx_ready is high only while idle.
module serial_frame_tx
    import serial_link_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_serial,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    link_state_t       state, state_nx;
    logic [DATA_W-1:0] shift_reg, shift_nx;
    logic [IDX_W-1:0]  bit_idx, bit_idx_nx;
    logic              parity_bit, parity_nx;
    logic              serial_nx, ready_nx, busy_nx, done_nx;
    logic              tick, pre_tick;
    logic [MAX_DATA_W-1:0] data_ext;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == IDLE),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    always_comb begin
        data_ext = '0;
        data_ext[DATA_W-1:0] = tx_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_idx    <= '0;
            parity_bit <= 1'b0;
            tx_serial  <= LINE_IDLE;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            shift_reg  <= shift_nx;
            bit_idx    <= bit_idx_nx;
            parity_bit <= parity_nx;
            tx_serial  <= serial_nx;
            tx_ready   <= ready_nx;
            busy       <= busy_nx;
            done       <= done_nx;
        end
    end

    // Every output is computed one cycle ahead so the line changes exactly on bit boundaries.
    always_comb begin
        state_nx   = state;
        shift_nx   = shift_reg;
        bit_idx_nx = bit_idx;
        parity_nx  = parity_bit;
        serial_nx  = tx_serial;
        ready_nx   = tx_ready;
        busy_nx    = busy;
        done_nx    = 1'b0;

        case (state)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    state_nx   = START;
                    shift_nx   = tx_data;
                    parity_nx  = even_parity(data_ext);
                    bit_idx_nx = '0;
                    serial_nx  = START_LVL;
                    ready_nx   = 1'b0;
                    busy_nx    = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_nx   = DATA;
                    bit_idx_nx = '0;
                    serial_nx  = shift_reg[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == LAST_IDX) begin
                        if (PARITY_EN != 0) begin
                            state_nx  = PARITY;
                            serial_nx = parity_bit;
                        end else begin
                            state_nx  = STOP;
                            serial_nx = STOP_LVL;
                        end
                    end else begin
                        shift_nx   = shift_reg >> 1;
                        bit_idx_nx = bit_idx + IDX_W'(1);
                        serial_nx  = shift_nx[0];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_nx  = STOP;
                    serial_nx = STOP_LVL;
                end
            end
            STOP: begin
                if (pre_tick) begin
                    done_nx = 1'b1;
                end
                if (tick) begin
                    state_nx  = IDLE;
                    serial_nx = LINE_IDLE;
                    ready_nx  = 1'b1;
                    busy_nx   = 1'b0;
                end
            end
            default: begin
                state_nx  = IDLE;
                serial_nx = LINE_IDLE;
                ready_nx  = 1'b1;
                busy_nx   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: one parity-enabled and one parity-less instance at 4 clocks per bit.
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_a = '0, data_b = '0;
    logic       valid_a = 1'b0, valid_b = 1'b0;
    logic       ready_a, serial_a, busy_a, done_a;
    logic       ready_b, serial_b, busy_b, done_b;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut (
        .clk(clk), .reset(reset), .tx_data(data_a), .tx_valid(valid_a),
        .tx_ready(ready_a), .tx_serial(serial_a), .busy(busy_a), .done(done_a)
    );

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut_np (
        .clk(clk), .reset(reset), .tx_data(data_b), .tx_valid(valid_b),
        .tx_ready(ready_b), .tx_serial(serial_b), .busy(busy_b), .done(done_b)
    );

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks++; if (serial_a !== 1'b1) $display("FAIL reset_serial: got %b expected 1", serial_a); else passes++;
        checks++; if (ready_a !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready_a); else passes++;
        checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_a); else passes++;
        checks++; if (done_a !== 1'b0) $display("FAIL reset_done: got %b expected 0", done_a); else passes++;
        checks++; if (serial_b !== 1'b1) $display("FAIL reset_serial_np: got %b expected 1", serial_b); else passes++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // exp_bits[i] is the line level of frame bit i (start first); each bit lasts 4 cycles.
    task automatic run_frame(input bit use_b, input logic [7:0] word, input int nbits,
                             input logic [10:0] exp_bits, input string tag, input bit scramble);
        int badcnt[11];
        int busy_cnt = 0, done_cnt = 0, done_at = -1, rdy_hi = 0;
        logic ser, bsy, dn, rdy;
        for (int i = 0; i < 11; i++) badcnt[i] = 0;
        @(negedge clk);
        if (use_b) begin data_b = word; valid_b = 1'b1; end
        else begin data_a = word; valid_a = 1'b1; end
        for (int c = 1; c <= nbits * 4; c++) begin
            @(negedge clk);
            ser = use_b ? serial_b : serial_a;
            bsy = use_b ? busy_b : busy_a;
            dn  = use_b ? done_b : done_a;
            rdy = use_b ? ready_b : ready_a;
            if (ser !== exp_bits[(c - 1) / 4]) badcnt[(c - 1) / 4]++;
            if (bsy === 1'b1) busy_cnt++;
            if (dn === 1'b1) begin done_cnt++; done_at = c; end
            if (rdy !== 1'b0) rdy_hi++;
            if (use_b) begin
                valid_b = scramble ? c[0] : 1'b0;
                if (scramble) data_b = 8'($urandom);
            end else begin
                valid_a = scramble ? c[0] : 1'b0;
                if (scramble) data_a = 8'($urandom);
            end
        end
        for (int i = 0; i < nbits; i++) begin
            checks++;
            if (badcnt[i] !== 0)
                $display("FAIL %s_bit%0d: wrong level in %0d of 4 cycles, expected %b", tag, i, badcnt[i], exp_bits[i]);
            else passes++;
        end
        checks++; if (busy_cnt !== nbits * 4) $display("FAIL %s_busy_len: got %0d expected %0d", tag, busy_cnt, nbits * 4); else passes++;
        checks++; if (done_cnt !== 1) $display("FAIL %s_done_count: got %0d expected 1", tag, done_cnt); else passes++;
        checks++; if (done_at !== nbits * 4) $display("FAIL %s_done_cycle: got %0d expected %0d", tag, done_at, nbits * 4); else passes++;
        checks++; if (rdy_hi !== 0) $display("FAIL %s_ready_low: ready high in %0d cycles, expected 0", tag, rdy_hi); else passes++;
        @(negedge clk);
        rdy = use_b ? ready_b : ready_a;
        ser = use_b ? serial_b : serial_a;
        bsy = use_b ? busy_b : busy_a;
        checks++; if (rdy !== 1'b1) $display("FAIL %s_ready_return: got %b expected 1", tag, rdy); else passes++;
        checks++; if (ser !== 1'b1) $display("FAIL %s_idle_line: got %b expected 1", tag, ser); else passes++;
        checks++; if (bsy !== 1'b0) $display("FAIL %s_idle_busy: got %b expected 0", tag, bsy); else passes++;
    endtask

    task automatic test_single_parity();
        // 0xA5: start 0, 1,0,1,0,0,1,0,1, parity 0, stop 1
        run_frame(1'b0, 8'hA5, 11, 11'b10101001010, "a5", 1'b0);
    endtask

    task automatic test_no_parity();
        // 0x01 without parity: start 0, 1, seven 0s, stop 1
        run_frame(1'b1, 8'h01, 10, 11'b11000000010, "np01", 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [10:0] f1 = 11'b10111111110;
        logic [10:0] f2 = 11'b10000000000;
        int bad1 = 0, bad2 = 0, tail_bad = 0, done_cnt = 0, rdy_cnt = 0;
        int done44 = 0, done89 = 0;
        logic rdy45 = 1'b0, ser45 = 1'b0;
        @(negedge clk);
        data_a = 8'hFF; valid_a = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c <= 44) begin
                if (serial_a !== f1[(c - 1) / 4]) bad1++;
            end else if (c == 45) begin
                ser45 = serial_a; rdy45 = ready_a;
            end else if (c <= 89) begin
                if (serial_a !== f2[(c - 46) / 4]) bad2++;
            end else begin
                if (serial_a !== 1'b1) tail_bad++;
            end
            if (done_a === 1'b1) begin
                done_cnt++;
                if (c == 44) done44 = 1;
                if (c == 89) done89 = 1;
            end
            if (c <= 89 && ready_a === 1'b1) rdy_cnt++;
            if (c == 1) data_a = 8'h00;
            if (c == 46) valid_a = 1'b0;
        end
        checks++; if (bad1 !== 0) $display("FAIL b2b_frame_ff: %0d wrong cycles, expected 0", bad1); else passes++;
        checks++; if (ser45 !== 1'b1) $display("FAIL b2b_idle_gap: got %b expected 1", ser45); else passes++;
        checks++; if (rdy45 !== 1'b1) $display("FAIL b2b_ready_gap: got %b expected 1", rdy45); else passes++;
        checks++; if (bad2 !== 0) $display("FAIL b2b_frame_00: %0d wrong cycles, expected 0", bad2); else passes++;
        checks++; if (rdy_cnt !== 1) $display("FAIL b2b_ready_cycles: got %0d expected 1", rdy_cnt); else passes++;
        checks++; if (done_cnt !== 2) $display("FAIL b2b_done_count: got %0d expected 2", done_cnt); else passes++;
        checks++; if (done44 + done89 !== 2) $display("FAIL b2b_done_cycles: got %0d on-time pulses expected 2", done44 + done89); else passes++;
        checks++; if (tail_bad !== 0) $display("FAIL b2b_no_third_frame: %0d low cycles, expected 0", tail_bad); else passes++;
    endtask

    task automatic test_mid_reset();
        int done_cnt = 0, low_cnt = 0;
        @(negedge clk);
        data_a = 8'h3C; valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        repeat (17) @(negedge clk);
        // cycle 18: inside data bit 3
        checks++; if (busy_a !== 1'b1) $display("FAIL midrst_busy_before: got %b expected 1", busy_a); else passes++;
        #1 reset = 1'b1;
        #1;
        checks++; if (serial_a !== 1'b1) $display("FAIL midrst_line: got %b expected 1", serial_a); else passes++;
        checks++; if (busy_a !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy_a); else passes++;
        checks++; if (ready_a !== 1'b1) $display("FAIL midrst_ready: got %b expected 1", ready_a); else passes++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done_a !== 1'b0) done_cnt++;
            if (serial_a !== 1'b1) low_cnt++;
        end
        checks++; if (done_cnt !== 0) $display("FAIL midrst_no_done: got %0d pulses expected 0", done_cnt); else passes++;
        checks++; if (low_cnt !== 0) $display("FAIL midrst_line_idle: got %0d low cycles expected 0", low_cnt); else passes++;
        // 0x3C: start 0, 0,0,1,1,1,1,0,0, parity 0, stop 1
        run_frame(1'b0, 8'h3C, 11, 11'b10001111000, "after_rst", 1'b0);
    endtask

    task automatic test_busy_ignore();
        // 0x07 latched, then data scrambled and valid toggled: 0, 1,1,1,0,0,0,0,0, parity 1, stop 1
        run_frame(1'b0, 8'h07, 11, 11'b11000001110, "scramble07", 1'b1);
    endtask

    initial begin
        test_reset();
        test_single_parity();
        test_no_parity();
        test_back_to_back();
        test_mid_reset();
        test_busy_ignore();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
